// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: controller FSM states, FIFO entry
// layout and the default FIFO depth.
package uart_pkg;

  localparam int DEFAULT_DEPTH = 8;
  localparam int ENTRY_W       = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PUSH  = 2'd1,
    CLEAR = 2'd2,
    WAIT  = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic       perr;
    logic [7:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO with show-ahead head output. The full test uses the
// pre-pop occupancy, so a push into a full FIFO is dropped even alongside a pop.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               clr_i,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic               pop_i,
  output logic [ENTRY_W-1:0] rdata_o,
  output logic               empty_o,
  output logic               full_o,
  output logic [ADDR_W:0]    count_o
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]    count_q;
  logic               push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive controller: captures each receiver byte once, queues it, re-arms the
// receiver. Define UART_RX_CTRL_PERR_DROP_EN to discard parity-error bytes.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            rdrf,
  input  logic [7:0]      rx_data,
  input  logic            prty_err,
  output logic            rdrf_clr,
  output logic            rx_clr,
  input  logic            sw_restart,
  input  logic            rd_en,
  output logic [7:0]      rd_data,
  output logic            rd_perr,
  output logic            empty,
  output logic            full,
  output logic [ADDR_W:0] count,
  output logic            overrun,
  input  logic            ovr_clr,
  output logic [7:0]      perr_cnt,
  output logic            irq
);

`ifdef UART_RX_CTRL_PERR_DROP_EN
  localparam logic PERR_DROP = 1'b1;
`else
  localparam logic PERR_DROP = 1'b0;
`endif

  rx_state_e state_q;
  rx_entry_t hold_q, head;
  logic      rdrf_clr_q, overrun_q, clr_dly_q, rx_clr_q, rx_clr_d;
  logic [7:0] perr_cnt_q;
  logic      drop_perr, push;

  assign drop_perr = PERR_DROP & hold_q.perr;
  assign push      = (state_q == PUSH) && !drop_perr;

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk_i   (clk),
    .clr_i   (clr),
    .push_i  (push),
    .wdata_i (hold_q),
    .pop_i   (rd_en),
    .rdata_o (head),
    .empty_o (empty),
    .full_o  (full),
    .count_o (count)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      rdrf_clr_q <= 1'b0;
      overrun_q  <= 1'b0;
      perr_cnt_q <= '0;
    end else begin
      rdrf_clr_q <= 1'b0;
      if (ovr_clr) overrun_q <= 1'b0;
      case (state_q)
        IDLE: if (rdrf) begin
          hold_q  <= '{perr: prty_err, data: rx_data};
          state_q <= PUSH;
        end
        PUSH: begin
          // a dropped parity byte never counts as an overrun
          if (drop_perr) begin
            if (perr_cnt_q != 8'hFF) perr_cnt_q <= perr_cnt_q + 8'd1;
          end else if (full) begin
            overrun_q <= 1'b1;
          end
          rdrf_clr_q <= 1'b1;
          state_q    <= CLEAR;
        end
        CLEAR: state_q <= WAIT;
        WAIT:  if (!rdrf) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (sw_restart) begin
        state_q    <= IDLE;
        rdrf_clr_q <= 1'b0;
      end
    end
  end

  // stretch the receiver restart one cycle past the end of clr
  assign rx_clr_d = clr | clr_dly_q | sw_restart;

  always_ff @(posedge clk) begin
    clr_dly_q <= clr;
    rx_clr_q  <= rx_clr_d;
  end

  assign rdrf_clr = rdrf_clr_q;
  assign rx_clr   = rx_clr_q;
  assign overrun  = overrun_q;
  assign perr_cnt = perr_cnt_q;
  assign rd_data  = head.data;
  assign rd_perr  = head.perr & ~PERR_DROP;
  assign irq      = !empty | overrun_q;

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART receiver in the MIPS-UART subsystem. It detects the receiver's data-ready flag and captures the received byte and parity status into a small FIFO. It then pulses the receiver's flag-clear input, so the receiver is re-armed without CPU involvement. The CPU side gets a show-ahead FIFO read port, a sticky overrun flag and a level interrupt.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- ADDR_W, $clog2(DEPTH), FIFO pointer width.

Ports:
- clk  in  1  system clock.
- clr  in  1  synchronous, active-high reset.
- rdrf  in  1  receiver data-ready flag; level, held until cleared.
- rx_data  in  8  receiver byte; valid while rdrf=1.
- prty_err  in  1  receiver parity-error flag; valid while rdrf=1.
- rdrf_clr  out  1  one-cycle pulse that clears the receiver flag.
- rx_clr  out  1  receiver restart; high while clr=1, for one cycle after clr falls, and one cycle after sw_restart.
- sw_restart  in  1  CPU request to restart the receiver.
- rd_en  in  1  pop head entry; ignored when empty.
- rd_data  out  8  head byte; show-ahead.
- rd_perr  out  1  head entry parity flag.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- count  out  ADDR_W+1  occupancy.
- overrun  out  1  sticky; a byte was dropped because the FIFO was full.
- ovr_clr  in  1  clears overrun.
- perr_cnt  out  8  saturating count of dropped parity-error bytes; stays 0 unless the macro is enabled.
- irq  out  1  level interrupt: !empty | overrun.

## Operation
- FSM states:
  - IDLE: if rdrf=1, latch rx_data/prty_err into a holding register; go to PUSH.
  - PUSH: if full, set overrun and drop the byte; otherwise write the holding register into the FIFO. Go to CLEAR.
  - CLEAR: rdrf_clr=1 for exactly this cycle; go to WAIT.
  - WAIT: stay until rdrf=0, then go to IDLE. This guarantees a single capture per received byte.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - full and empty are derived from count.
  - rd_data/rd_perr come combinationally from the head entry; they are 0 when empty.
- Simultaneous push and pop:
  - The full test uses the pre-pop count. A push while full is dropped even if rd_en=1 in the same cycle; the pop still happens.
  - When not full, push and pop together leave count unchanged.
- Overrun set and ovr_clr in the same cycle: set wins.
- sw_restart:
  - Pulses rx_clr on the next cycle and forces the FSM to IDLE.
  - FIFO contents are kept.
  - A byte in PUSH in that same cycle is still written.
- Reset (clr=1), at any state: FSM→IDLE, pointers/count→0, overrun→0, perr_cnt→0, rdrf_clr→0, rx_clr→1. A capture in progress is abandoned.

## Timing
- All outputs are registered except rd_data, rd_perr, empty, full and irq, which decode registered state.
- Reset values: rdrf_clr=0, rx_clr=1, rd_data=0, rd_perr=0, empty=1, full=0, count=0, overrun=0, perr_cnt=0, irq=0.
- Latency for rdrf sampled high at edge N:
  - FIFO write at edge N+1; count and empty update after edge N+1.
  - rdrf_clr high during cycle N+2.
  - Earliest next capture: two cycles after rdrf is seen low in WAIT.
- rd_en at edge M: the new head is visible after edge M.
- Minimum byte spacing from the receiver is thousands of cycles, so the FSM is never the throughput limit.

## Configuration
- Macro: UART_RX_CTRL_PERR_DROP_EN.
- Defined:
  - In PUSH, bytes with prty_err=1 are not stored; perr_cnt increments, saturating at 255.
  - The CLEAR/WAIT sequence still runs.
  - rd_perr is always 0.
- Undefined:
  - All bytes are stored, with the parity flag per entry.
  - perr_cnt is tied to 0.

## Structure
- Shared package uart_pkg:
  - FSM state enum (IDLE, PUSH, CLEAR, WAIT; 2 bits).
  - Default DEPTH constant.
  - FIFO entry typedef: {perr, byte[7:0]}, 9 bits.
- Sub-module uart_rx_fifo:
  - Parameterised by DEPTH.
  - Push/pop/count/full/empty logic plus show-ahead read.
  - The controller FSM, overrun logic, perr_cnt and rx_clr stay in uart_rx_ctrl.

## Test plan
- Reset: hold clr 3 cycles → rx_clr=1 for 4 cycles total, empty=1, count=0, irq=0, rdrf_clr=0.
- Single byte: rdrf=1 with rx_data=0xA5, prty_err=0 → rdrf_clr pulses 2 cycles later for 1 cycle; rd_data=0xA5, count=1, irq=1; rd_en → empty=1, irq=0.
- Overrun: push 8 bytes 0x00..0x07, then 0x3C → overrun=1, count=8, head=0x00, 0x3C never read; ovr_clr → overrun=0.
- Parity: rx_data=0x55 with prty_err=1. Macro off → stored, rd_perr=1. Macro on → count unchanged, perr_cnt=1, rdrf_clr still pulses.
- Simultaneous: count=3, push 0x7E in the same cycle as rd_en → count=3, 0x7E at tail. At count=8, push plus pop → count=7, overrun=1.
- Mid-operation reset: assert clr while in WAIT with rdrf still high → IDLE, count=0, no rdrf_clr pulse. After release, rdrf still high → one fresh capture.
